// File: rtl/ddr_pkg.sv
// Shared types for the DDR port scheduler: controller command codes and FSM states.
// No logic of its own; the helper function is pure combinational arithmetic.
// No flow control here; users apply it in their own handshakes.
package ddr_pkg;

    typedef enum logic [2:0] {
        CMD_WRITE = 3'b000,
        CMD_READ  = 3'b001
    } ddr_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } sched_state_t;

    // Port index 'off' places after 'base', wrapping modulo n (off < n, base < n).
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/ddr_port_scheduler_if.sv
// Push/pop channel between the scheduler and its read-tag FIFO.
// Purely structural; no latency of its own.
// Producer must not push when full unless popping the same cycle; pop is ignored when empty.
interface ddr_port_scheduler_if #(
    parameter int WIDTH = 1
);
    logic             push_vld;
    logic [WIDTH-1:0] push_dat;
    logic             pop_vld;
    logic [WIDTH-1:0] pop_dat;
    logic             full;
    logic             empty;

    modport master (
        output push_vld, push_dat, pop_vld,
        input  pop_dat, full, empty
    );

    modport slave (
        input  push_vld, push_dat, pop_vld,
        output pop_dat, full, empty
    );
endinterface

// File: rtl/ddr_tag_fifo.sv
// Synchronous FIFO of port indices for outstanding reads, returned in issue order.
// pop_dat shows the head combinationally; a push is visible at the head one cycle later.
// Full blocks a lone push; push+pop in the same cycle is accepted even when full.
module ddr_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    ddr_port_scheduler_if.slave tag_if
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign tag_if.full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign tag_if.empty   = (count_q == '0);
    assign tag_if.pop_dat = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = tag_if.pop_vld & ~tag_if.empty;
        do_push  = tag_if.push_vld & (~tag_if.full | do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = tag_if.push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ddr_port_scheduler.sv
// Round-robin scheduler of N single-beat ports onto a DDR controller app interface.
// Hold->command >= 3 cycles (IDLE, ARB, issue); read data reaches the port 1 cycle after return.
// Per-port ready drops while its hold is full; reads stall while the tag FIFO is full.
module ddr_port_scheduler
    import ddr_pkg::*;
#(
    parameter  int NUM_PORTS  = 2,
    parameter  int ADDR_WIDTH = 27,
    parameter  int DATA_WIDTH = 64,
    parameter  int TAG_DEPTH  = 16,
    localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [NUM_PORTS-1:0]                 port_req_i,
    input  logic [NUM_PORTS-1:0]                 port_write_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_wdata_i,
    input  logic [NUM_PORTS-1:0][MASK_WIDTH-1:0] port_wmask_i,
    output logic [NUM_PORTS-1:0]                 port_ready_o,
    output logic [DATA_WIDTH-1:0]                port_rdata_o,
    output logic [NUM_PORTS-1:0]                 port_rvalid_o,
    input  logic                                 init_calib_complete_i,
    output logic                                 app_en_o,
    output logic [2:0]                           app_cmd_o,
    output logic [ADDR_WIDTH-1:0]                app_addr_o,
    input  logic                                 app_rdy_i,
    output logic                                 app_wdf_wren_o,
    output logic                                 app_wdf_end_o,
    output logic [DATA_WIDTH-1:0]                app_wdf_data_o,
    output logic [MASK_WIDTH-1:0]                app_wdf_mask_o,
    input  logic                                 app_wdf_rdy_i,
    input  logic [DATA_WIDTH-1:0]                app_rd_data_i,
    input  logic                                 app_rd_data_valid_i,
    output logic                                 err_o
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Per-port holding registers.
    logic [NUM_PORTS-1:0]                 hold_vld_q, hold_vld_d;
    logic [NUM_PORTS-1:0]                 hold_wr_q, hold_wr_d;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [NUM_PORTS-1:0][MASK_WIDTH-1:0] hold_mask_q, hold_mask_d;

    // Scheduler state.
    sched_state_t         state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 cmd_done_q, cmd_done_d;
    logic                 wdf_done_q, wdf_done_d;

    // Read return path.
    logic                 err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;

    // Combinational helpers.
    logic [NUM_PORTS-1:0] ready_int;
    logic [NUM_PORTS-1:0] load;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] hold_clr;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;
    logic                 app_en;
    logic                 app_wren;
    ddr_cmd_t             app_cmd;
    logic                 cmd_acc;
    logic                 wdf_acc;
    logic                 tag_push;
    logic                 tag_pop;

    ddr_port_scheduler_if #(.WIDTH(IDX_W)) tag_if ();

    ddr_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (IDX_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .tag_if  (tag_if)
    );

    assign tag_if.push_vld = tag_push;
    assign tag_if.push_dat = grant_q;
    assign tag_if.pop_vld  = tag_pop;

    assign ready_int = ~hold_vld_q & {NUM_PORTS{init_calib_complete_i}};
    assign load      = port_req_i & ready_int;
    // A read may only win if its tag has somewhere to go.
    assign eligible  = hold_vld_q & (hold_wr_q | {NUM_PORTS{~tag_if.full}});

    // Round-robin pick: scan from farthest to nearest so the port closest after the pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = IDX_W'(rr_wrap(int'(rr_ptr_q), k, NUM_PORTS));
            if (eligible[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Scheduler FSM next-state and controller-side outputs.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cmd_done_d = cmd_done_q;
        wdf_done_d = wdf_done_q;
        app_en     = 1'b0;
        app_wren   = 1'b0;
        app_cmd    = CMD_WRITE;
        cmd_acc    = 1'b0;
        wdf_acc    = 1'b0;
        tag_push   = 1'b0;
        hold_clr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (init_calib_complete_i && (|hold_vld_q)) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (pick_vld) begin
                    grant_d    = pick_idx;
                    rr_ptr_d   = IDX_W'(rr_wrap(int'(pick_idx), 1, NUM_PORTS));
                    cmd_done_d = 1'b0;
                    wdf_done_d = 1'b0;
                    state_d    = hold_wr_q[pick_idx] ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                app_en   = ~cmd_done_q;
                app_wren = ~wdf_done_q;
                app_cmd  = CMD_WRITE;
                cmd_acc  = app_en & app_rdy_i;
                wdf_acc  = app_wren & app_wdf_rdy_i;
                if ((cmd_done_q | cmd_acc) && (wdf_done_q | wdf_acc)) begin
                    hold_clr[grant_q] = 1'b1;
                    cmd_done_d        = 1'b0;
                    wdf_done_d        = 1'b0;
                    state_d           = ST_IDLE;
                end else begin
                    cmd_done_d = cmd_done_q | cmd_acc;
                    wdf_done_d = wdf_done_q | wdf_acc;
                end
            end
            ST_READ: begin
                app_en  = 1'b1;
                app_cmd = CMD_READ;
                if (app_rdy_i) begin
                    tag_push          = 1'b1;
                    hold_clr[grant_q] = 1'b1;
                    state_d           = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Holding registers: load on req & ready, clear when the granted command completes.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_wr_d   = hold_wr_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_mask_d = hold_mask_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (hold_clr[i]) begin
                hold_vld_d[i] = 1'b0;
            end
            if (load[i]) begin
                hold_vld_d[i]  = 1'b1;
                hold_wr_d[i]   = port_write_i[i];
                hold_addr_d[i] = port_addr_i[i];
                hold_data_d[i] = port_wdata_i[i];
                hold_mask_d[i] = port_wmask_i[i];
            end
        end
    end

    // Read return: route each beat to the oldest tag, flag beats with no tag outstanding.
    always_comb begin
        tag_pop  = app_rd_data_valid_i & ~tag_if.empty;
        err_d    = err_q | (app_rd_data_valid_i & tag_if.empty);
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_pop) begin
            rvalid_d[tag_if.pop_dat] = 1'b1;
            rdata_d                  = app_rd_data_i;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hold_vld_q  <= '0;
            hold_wr_q   <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_mask_q <= '0;
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            cmd_done_q  <= 1'b0;
            wdf_done_q  <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_wr_q   <= hold_wr_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_mask_q <= hold_mask_d;
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_done_q  <= cmd_done_d;
            wdf_done_q  <= wdf_done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Reset is synchronous, so outputs are forced low while rst_n_i is asserted
    // rather than waiting for the next edge to clear the state behind them.
    assign port_ready_o   = rst_n_i ? ready_int : '0;
    assign port_rdata_o   = rst_n_i ? rdata_q : '0;
    assign port_rvalid_o  = rst_n_i ? rvalid_q : '0;
    assign err_o          = rst_n_i & err_q;
    assign app_en_o       = rst_n_i & app_en;
    assign app_cmd_o      = rst_n_i ? app_cmd : CMD_WRITE;
    assign app_addr_o     = rst_n_i ? hold_addr_q[grant_q] : '0;
    assign app_wdf_wren_o = rst_n_i & app_wren;
    assign app_wdf_end_o  = rst_n_i & app_wren;
    assign app_wdf_data_o = rst_n_i ? hold_data_q[grant_q] : '0;
    assign app_wdf_mask_o = rst_n_i ? hold_mask_q[grant_q] : '0;

endmodule

// File: doc/ddr_port_scheduler.md
DDR_PORT_SCHEDULER -- requirements
Module: ddr_port_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requester ports, range 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 27: DRAM application address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: application data width; MASK_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter TAG_DEPTH, default 16: maximum outstanding reads; power of two.
REQ-005 SHALL have port clk_i, in, 1: single clock, the memory controller UI clock domain.
REQ-006 SHALL have port rst_n_i, in, 1: reset, synchronous, active-low.
REQ-007 SHALL have port port_req_i, in, NUM_PORTS: per-port command request.
REQ-008 SHALL have port port_write_i, in, NUM_PORTS: command type per port; 1 = write, 0 = read.
REQ-009 SHALL have port port_addr_i, in, NUM_PORTS x ADDR_WIDTH: per-port address.
REQ-010 SHALL have port port_wdata_i, in, NUM_PORTS x DATA_WIDTH: per-port write data.
REQ-011 SHALL have port port_wmask_i, in, NUM_PORTS x MASK_WIDTH: per-port byte mask; 1 = byte not written.
REQ-012 SHALL have port port_ready_o, out, NUM_PORTS: holding slot free; a command is accepted when req & ready.
REQ-013 SHALL have port port_rdata_o, out, DATA_WIDTH: read data, shared by all ports.
REQ-014 SHALL have port port_rvalid_o, out, NUM_PORTS: one-hot read-data valid for the owning port.
REQ-015 SHALL have port init_calib_complete_i, in, 1: controller calibration done.
REQ-016 SHALL have ports app_en_o (out, 1), app_cmd_o (out, 3) and app_addr_o (out, ADDR_WIDTH): controller command channel.
REQ-017 SHALL have port app_rdy_i, in, 1: command accepted when app_en_o & app_rdy_i.
REQ-018 SHALL have ports app_wdf_wren_o (out, 1), app_wdf_end_o (out, 1), app_wdf_data_o (out, DATA_WIDTH) and app_wdf_mask_o (out, MASK_WIDTH): write-data channel.
REQ-019 SHALL have port app_wdf_rdy_i, in, 1: write beat accepted when app_wdf_wren_o & app_wdf_rdy_i.
REQ-020 SHALL have ports app_rd_data_i (in, DATA_WIDTH) and app_rd_data_valid_i (in, 1): read-return channel, one beat per read.
REQ-021 SHALL have port err_o, out, 1: sticky error flag, set on read data with no outstanding tag.

Function
REQ-022 SHALL give each port a one-entry holding register (valid, type, addr, data, mask); port_ready_o[i] = !valid[i] & init_calib_complete_i.
REQ-023 SHALL use FSM IDLE -> ARB -> WRITE or READ -> IDLE; ARB is one cycle and registers the grant.
REQ-024 SHALL arbitrate round-robin among valid holds, starting at the port after the last grant; pointer resets to port 0.
REQ-025 SHALL exclude read holds from arbitration while the tag FIFO is full; write holds remain eligible; no valid eligible hold in ARB -> IDLE.
REQ-026 WRITE SHALL assert app_en_o (app_cmd_o = 3'b000) and app_wdf_wren_o with app_wdf_end_o = 1, drop each independently once accepted, and return to IDLE when both are accepted (any order, same cycle allowed).
REQ-027 READ SHALL assert app_en_o (app_cmd_o = 3'b001) until app_rdy_i, push the granted port index into the tag FIFO in the acceptance cycle, then return to IDLE.
REQ-028 SHALL clear the granted hold in the cycle the command completes; the port may reload it from the next cycle.
REQ-029 SHALL, on app_rd_data_valid_i, pop the tag FIFO and one cycle later drive port_rdata_o = the data and port_rvalid_o = one-hot(tag) for exactly one cycle; returns are in issue order.
REQ-030 SHALL support a tag-FIFO push and pop in the same cycle, leaving occupancy unchanged, including when the FIFO is full.
REQ-031 SHALL, on app_rd_data_valid_i with an empty tag FIFO, set err_o, drop the beat and assert no port_rvalid_o.
REQ-032 SHALL hold the FSM in IDLE while init_calib_complete_i is low; a command in flight completes normally.

Reset
REQ-033 SHALL, with rst_n_i low at a clk_i edge, clear all holds, the tag FIFO, the round-robin pointer and err_o, set the FSM to IDLE, and abandon any in-flight transfer.
REQ-034 SHALL drive all outputs to 0 during reset; port_ready_o becomes valid from the first cycle after reset.

Structure
REQ-035 SHALL define the ddr_cmd_t enum (CMD_WRITE = 3'b000, CMD_READ = 3'b001) and the scheduler state enum in shared package ddr_pkg.
REQ-036 SHALL implement the tag FIFO as sub-module ddr_tag_fifo (synchronous; parameters DEPTH and WIDTH = $clog2(NUM_PORTS)).

Verification
REQ-037 SHALL check: port0 write addr 0x100, data 0xA5A5, app_rdy_i and app_wdf_rdy_i high -> one command 3'b000 at 0x100 plus one beat with wdf_end = 1.
REQ-038 SHALL check: ports 0 and 1 both request continuously -> grants alternate 0,1,0,1.
REQ-039 SHALL check: reads from ports 1, 0, 1 with data returned as D1, D2, D3 -> rvalid one-hot 2'b10, 2'b01, 2'b10, each one cycle after its return.
REQ-040 SHALL check: 16 outstanding reads with a write pending -> the write still issues and a 17th read waits until the first return.
REQ-041 SHALL check: app_rd_data_valid_i pulsed with no reads outstanding -> err_o = 1 and stays set until reset.
REQ-042 SHALL check: rst_n_i low during WRITE with app_wdf_rdy_i low -> all outputs 0, and after release port_ready_o = all ones once calibration is complete.
